// File: rtl/tx_filt_pkg.sv
// rtl/tx_filt_pkg.sv - shared constants, coefficient table and phase-state type for the tx/rx filters
package tx_filt_pkg;

    localparam int UPSAMPLE = 4;
    localparam int NUM_TAPS = 31;
    localparam int NUM_UNIQ = 16;
    localparam int CENTRE   = 15;

    localparam logic signed [17:0] LVL_OUTER = 18'sd98304;
    localparam logic signed [17:0] LVL_INNER = 18'sd32768;

    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [21:0] SAT_MAX = 22'sd131071;
    localparam logic signed [21:0] SAT_MIN = -22'sd131071;

    localparam logic [1:0] SYM_NEG_OUTER = 2'b00;
    localparam logic [1:0] SYM_NEG_INNER = 2'b01;
    localparam logic [1:0] SYM_POS_INNER = 2'b10;
    localparam logic [1:0] SYM_POS_OUTER = 2'b11;

    // Unique half of the symmetric impulse response, 1s17; index 15 is the centre tap.
    typedef logic [0:NUM_UNIQ-1][17:0] coef_t;

    localparam coef_t COEF = '{
        -18'sd3566,  18'sd0, -18'sd4114,  18'sd0,
         18'sd4863,  18'sd0,  18'sd5943,  18'sd0,
        -18'sd7641,  18'sd0, -18'sd10698, 18'sd0,
         18'sd17829, 18'sd0,  18'sd0,     18'sd59411
    };

    typedef enum logic {
        PH_UNLOCKED = 1'b0,
        PH_LOCKED   = 1'b1
    } phase_state_e;

    function automatic logic signed [17:0] sym_level(input logic [1:0] sym);
        case (sym)
            SYM_NEG_OUTER: sym_level = -LVL_OUTER;
            SYM_NEG_INNER: sym_level = -LVL_INNER;
            SYM_POS_INNER: sym_level = LVL_INNER;
            default:       sym_level = LVL_OUTER;
        endcase
    endfunction

endpackage

// File: rtl/tx_pulse_shape_filt_if.sv
// rtl/tx_pulse_shape_filt_if.sv - symbol/sample strobe and shaped-sample bundle
interface tx_pulse_shape_filt_if;

    logic               sam_clk_en;
    logic               sym_clk_en;
    logic [1:0]         sym_in;
    logic signed [17:0] y;
    logic               sym_phase_err;

    modport master (
        output sam_clk_en,
        output sym_clk_en,
        output sym_in,
        input  y,
        input  sym_phase_err
    );

    modport slave (
        input  sam_clk_en,
        input  sym_clk_en,
        input  sym_in,
        output y,
        output sym_phase_err
    );

endinterface

// File: rtl/tx_pulse_shape_filt_phase.sv
// rtl/tx_pulse_shape_filt_phase.sv - symbol-phase counter, lock FSM and sticky misalignment flag
module tx_sym_phase_ctl
    import tx_filt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sam_clk_en_i,
    input  logic sym_clk_en_i,
    output logic sym_phase_err_o
);

    phase_state_e state_q, state_d;
    logic [1:0]   phase_q, phase_d;
    logic         err_q, err_d;

    // State register; everything holds between sample strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PH_UNLOCKED;
            phase_q <= 2'd0;
            err_q   <= 1'b0;
        end else if (sam_clk_en_i) begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    // Lock on the first symbol, then expect symbols only at phase 0 and realign on a stray one.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        err_d   = err_q;
        case (state_q)
            PH_UNLOCKED: begin
                if (sym_clk_en_i) begin
                    state_d = PH_LOCKED;
                    phase_d = 2'd1;
                end else begin
                    phase_d = 2'd0;
                end
            end
            PH_LOCKED: begin
                phase_d = (phase_q == 2'd3) ? 2'd0 : phase_q + 2'd1;
                if (sym_clk_en_i) begin
                    if (phase_q != 2'd0) begin
                        err_d = 1'b1;
                    end
                    phase_d = 2'd1;
                end else if (phase_q == 2'd0) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = PH_UNLOCKED;
        endcase
    end

    assign sym_phase_err_o = err_q;

endmodule

// File: rtl/tx_pulse_shape_filt.sv
// rtl/tx_pulse_shape_filt.sv - 4-ASK mapper, x4 zero-stuffing upsampler and folded 31-tap FIR
module tx_pulse_shape_filt
    import tx_filt_pkg::*;
#(
    parameter coef_t COEF_P = COEF
)
(
    input  logic                  clk,
    input  logic                  reset,
    tx_pulse_shape_filt_if.slave  bus
);

    logic signed [17:0] x_q [NUM_TAPS];
    logic signed [17:0] y_q, y_d;
    logic signed [17:0] level;
    logic signed [18:0] fold;
    logic signed [36:0] prod;
    logic signed [21:0] acc;

    assign level = sym_level(bus.sym_in);

    // Delay line and output register; a non-symbol sample pushes a stuffed zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_q[i] <= '0;
            end
            y_q <= '0;
        end else if (bus.sam_clk_en) begin
            x_q[0] <= bus.sym_clk_en ? level : 18'sd0;
            for (int i = 1; i < NUM_TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
            y_q <= y_d;
        end
    end

    // Folded FIR: pair mirrored taps, truncate each product to 1s17, accumulate, then clamp.
    always_comb begin
        acc  = '0;
        fold = '0;
        prod = '0;
        for (int i = 0; i < CENTRE; i++) begin
            fold = {x_q[i][17], x_q[i]} + {x_q[NUM_TAPS-1-i][17], x_q[NUM_TAPS-1-i]};
            prod = 37'(fold) * 37'($signed(COEF_P[i]));
            acc  = acc + 22'(prod >>> 17);
        end
        fold = {x_q[CENTRE][17], x_q[CENTRE]};
        prod = 37'(fold) * 37'($signed(COEF_P[CENTRE]));
        acc  = acc + 22'(prod >>> 17);
        if (acc > SAT_MAX) begin
            y_d = SAT_MAX[17:0];
        end else if (acc < SAT_MIN) begin
            y_d = SAT_MIN[17:0];
        end else begin
            y_d = acc[17:0];
        end
    end

    assign bus.y = y_q;

    tx_sym_phase_ctl u_phase (
        .clk             (clk),
        .reset           (reset),
        .sam_clk_en_i    (bus.sam_clk_en),
        .sym_clk_en_i    (bus.sym_clk_en),
        .sym_phase_err_o (bus.sym_phase_err)
    );

endmodule

// File: tb/tb_tx_pulse_shape_filt.sv
// tb/tb_tx_pulse_shape_filt.sv - scoreboard bench for the transmit pulse-shaping filter
module tb_tx_pulse_shape_filt;
    import tx_filt_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    localparam coef_t COEF_SAT = {16{18'd131071}};

    tx_pulse_shape_filt_if bus_a ();
    tx_pulse_shape_filt_if bus_s ();

    tx_pulse_shape_filt u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    tx_pulse_shape_filt #(.COEF_P(COEF_SAT)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    int     total = 0;
    int     bad   = 0;
    longint mx [31];
    longint q_a [$];
    longint q_s [$];
    longint last_a = 0;
    longint last_s = 0;
    longint obs_a  = 0;
    longint obs_s  = 0;
    longint resp [34];

    function automatic longint tb_level(input logic [1:0] si);
        case (si)
            2'b00:   return -98304;
            2'b01:   return -32768;
            2'b10:   return 32768;
            default: return 98304;
        endcase
    endfunction

    function automatic longint tb_coef(input int i, input bit sat);
        if (sat) return 131071;
        return longint'($signed(COEF[i]));
    endfunction

    function automatic longint model_y(input bit sat);
        longint t = 0;
        for (int i = 0; i < 15; i++) begin
            t += ((mx[i] + mx[30-i]) * tb_coef(i, sat)) >>> 17;
        end
        t += (mx[15] * tb_coef(15, sat)) >>> 17;
        if (t > 131071) t = 131071;
        if (t < -131071) t = -131071;
        return t;
    endfunction

    task automatic step(input bit rst, input bit sam, input bit sym, input logic [1:0] si);
        longint ea, es;
        reset = rst;
        bus_a.sam_clk_en = sam; bus_a.sym_clk_en = sym; bus_a.sym_in = si;
        bus_s.sam_clk_en = sam; bus_s.sym_clk_en = sym; bus_s.sym_in = si;
        if (rst) begin
            ea = 0; es = 0;
        end else if (sam) begin
            ea = model_y(1'b0); es = model_y(1'b1);
        end else begin
            ea = last_a; es = last_s;
        end
        q_a.push_back(ea);
        q_s.push_back(es);
        if (rst) begin
            for (int i = 0; i < 31; i++) mx[i] = 0;
        end else if (sam) begin
            for (int i = 30; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = sym ? tb_level(si) : 0;
        end
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        es = q_s.pop_front();
        last_a = ea;
        last_s = es;
        obs_a = longint'(bus_a.y);
        obs_s = longint'(bus_s.y);
        total++;
        if (obs_a !== ea) begin
            bad++;
            $display("FAIL y_main t=%0t: got %0d want %0d", $time, obs_a, ea);
        end
        total++;
        if (obs_s !== es) begin
            bad++;
            $display("FAIL y_satcoef t=%0t: got %0d want %0d", $time, obs_s, es);
        end
    endtask

    task automatic sym_block(input logic [1:0] si, input int n_after);
        step(1'b0, 1'b1, 1'b1, si);
        for (int i = 0; i < n_after; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic check_err(input string name, input logic want);
        total++;
        if (bus_a.sym_phase_err !== want) begin
            bad++;
            $display("FAIL %s: sym_phase_err got %b want %b", name, bus_a.sym_phase_err, want);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b11);
    endtask

    task automatic run_impulse(input logic [1:0] si);
        do_reset();
        step(1'b0, 1'b1, 1'b1, si);
        for (int k = 0; k < 34; k++) begin
            step(1'b0, 1'b1, 1'b0, 2'b00);
            resp[k] = obs_a;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus_a.y !== 18'sd0) begin
            bad++;
            $display("FAIL reset_y: got %0d want 0", bus_a.y);
        end
        check_err("reset_flag", 1'b0);
    endtask

    task automatic test_impulse();
        longint h;
        run_impulse(2'b11);
        for (int k = 0; k < 31; k++) begin
            h = (k <= 15) ? tb_coef(k, 1'b0) : tb_coef(30 - k, 1'b0);
            total++;
            if (resp[k] !== ((98304 * h) >>> 17)) begin
                bad++;
                $display("FAIL impulse_tap%0d: got %0d want %0d", k, resp[k], (98304 * h) >>> 17);
            end
        end
        total++;
        if (resp[15] !== 44558) begin
            bad++;
            $display("FAIL impulse_centre: got %0d want 44558", resp[15]);
        end
        for (int k = 31; k < 34; k++) begin
            total++;
            if (resp[k] !== 0) begin
                bad++;
                $display("FAIL impulse_tail%0d: got %0d want 0", k, resp[k]);
            end
        end
        check_err("missing_symbol_flag", 1'b1);
    endtask

    task automatic test_polarity();
        longint pos [34];
        run_impulse(2'b10);
        pos = resp;
        run_impulse(2'b01);
        for (int k = 0; k < 31; k++) begin
            total++;
            if (pos[k] + resp[k] > 1 || pos[k] + resp[k] < -1) begin
                bad++;
                $display("FAIL polarity%0d: got %0d want about %0d", k, resp[k], -pos[k]);
            end
        end
    endtask

    task automatic test_gating();
        longint hold;
        do_reset();
        step(1'b0, 1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 2'b00);
        hold = obs_a;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
            total++;
            if (obs_a !== hold) begin
                bad++;
                $display("FAIL gating_hold%0d: got %0d want %0d", k, obs_a, hold);
            end
        end
        for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic test_phase_err();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 2'b00);
        for (int b = 0; b < 3; b++) begin
            sym_block(2'b10, 3);
            check_err("locked_legal", 1'b0);
        end
        sym_block(2'b11, 1);
        check_err("before_offphase", 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        check_err("offphase_set", 1'b1);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        for (int b = 0; b < 2; b++) begin
            sym_block(2'b00, 3);
            check_err("sticky", 1'b1);
        end
        step(1'b1, 1'b1, 1'b1, 2'b11);
        check_err("cleared_by_reset", 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        sym_block(2'b11, 3);
        sym_block(2'b11, 1);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        total++;
        if (bus_a.y !== 18'sd0) begin
            bad++;
            $display("FAIL midreset_y: got %0d want 0", bus_a.y);
        end
        check_err("midreset_flag", 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        total++;
        if (obs_a !== 0) begin
            bad++;
            $display("FAIL first_after_release: got %0d want 0", obs_a);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 2'b00);
        for (int b = 0; b < 8; b++) sym_block(2'b00, 3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int b = 0; b < 40; b++) sym_block(2'($urandom_range(0, 3)), 3);
        check_err("b2b_no_err", 1'b0);
    endtask

    task automatic test_saturation();
        longint mn = 0;
        do_reset();
        for (int b = 0; b < 12; b++) begin
            sym_block(2'b11, 3);
            if (obs_s < mn) mn = obs_s;
        end
        total++;
        if (mn < 0) begin
            bad++;
            $display("FAIL sat_no_wrap: got min %0d want >= 0", mn);
        end
        total++;
        if (obs_s !== 131071) begin
            bad++;
            $display("FAIL sat_pos: got %0d want 131071", obs_s);
        end
        for (int b = 0; b < 12; b++) sym_block(2'b00, 3);
        total++;
        if (obs_s !== -131071) begin
            bad++;
            $display("FAIL sat_neg: got %0d want -131071", obs_s);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_a.sam_clk_en = 1'b0; bus_a.sym_clk_en = 1'b0; bus_a.sym_in = 2'b00;
        bus_s.sam_clk_en = 1'b0; bus_s.sym_clk_en = 1'b0; bus_s.sym_in = 2'b00;
        for (int i = 0; i < 31; i++) mx[i] = 0;
        test_reset();
        test_impulse();
        test_polarity();
        test_gating();
        test_phase_err();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
